// File: rtl/key_sched_pkg.sv
// Shared types and constants for the key event scheduler.
// Holds the per-key repeat FSM state type, key id constants, default
// DAS/ARR cycle counts and a small modulo helper used by the arbiter.
package key_sched_pkg;

    // Per-key repeat FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DAS  = 2'd1,
        ARR  = 2'd2,
        HOLD = 2'd3
    } key_state_e;

    // Key ids as wired from the input filter
    localparam int KEY_LEFT   = 0;
    localparam int KEY_RIGHT  = 1;
    localparam int KEY_ROTATE = 2;

    // Default delayed-auto-shift and auto-repeat periods in clock cycles
    localparam logic [23:0] DEFAULT_DAS_CYCLES = 24'd6_000_000;
    localparam logic [23:0] DEFAULT_ARR_CYCLES = 24'd1_500_000;

    // (a + b) mod n, valid for 0 <= a < n and 0 <= b < n
    function automatic int wrap_add(input int a, input int b, input int n);
        int s;
        s = a + b;
        return (s >= n) ? (s - n) : s;
    endfunction

endpackage

// File: rtl/key_repeat_timer.sv
// Per-key press detector with optional DAS/ARR repeat FSM.
// press_evt and rep_evt are single-cycle strobes decoded from the
// registered key level, FSM state and countdown.
// Optional feature macro: KEY_SCHED_REPEAT_EN (FSM and timer only exist when defined).
module key_repeat_timer
    import key_sched_pkg::*;
`ifdef KEY_SCHED_REPEAT_EN
#(
    parameter int unsigned          TIMER_W    = 24,
    parameter logic [TIMER_W-1:0]   DAS_CYCLES = TIMER_W'(DEFAULT_DAS_CYCLES),
    parameter logic [TIMER_W-1:0]   ARR_CYCLES = TIMER_W'(DEFAULT_ARR_CYCLES),
    parameter bit                   REPEAT_EN  = 1'b1
)
`endif
(
    input  logic clk,
    input  logic reset,
    input  logic key_in,
    output logic press_evt,
    output logic rep_evt
);

    logic key_prev_reg;

    // Rising edge of the clean key level
    assign press_evt = key_in & ~key_prev_reg;

    // Remember last cycle's key level for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            key_prev_reg <= 1'b0;
        end else begin
            key_prev_reg <= key_in;
        end
    end

`ifdef KEY_SCHED_REPEAT_EN
    key_state_e         state_reg;
    logic [TIMER_W-1:0] timer_reg;
    logic               timer_zero;

    assign timer_zero = (timer_reg == '0);

    // A repeat fires when a countdown expires while the key is still held;
    // in DAS this only happens for keys allowed to repeat.
    assign rep_evt = key_in & timer_zero &
                     (((state_reg == DAS) & REPEAT_EN) | (state_reg == ARR));

    // Repeat FSM and countdown; a released key always falls back to IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            timer_reg <= '0;
        end else if (!key_in) begin
            state_reg <= IDLE;
            timer_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!key_prev_reg) begin
                        state_reg <= DAS;
                        timer_reg <= DAS_CYCLES - TIMER_W'(1);
                    end
                end
                DAS: begin
                    if (timer_zero) begin
                        if (REPEAT_EN) begin
                            state_reg <= ARR;
                            timer_reg <= ARR_CYCLES - TIMER_W'(1);
                        end else begin
                            state_reg <= HOLD;
                        end
                    end else begin
                        timer_reg <= timer_reg - TIMER_W'(1);
                    end
                end
                ARR: begin
                    if (timer_zero) begin
                        timer_reg <= ARR_CYCLES - TIMER_W'(1);
                    end else begin
                        timer_reg <= timer_reg - TIMER_W'(1);
                    end
                end
                HOLD: begin
                    state_reg <= HOLD;
                end
                default: begin
                    state_reg <= IDLE;
                    timer_reg <= '0;
                end
            endcase
        end
    end
`else
    assign rep_evt = 1'b0;
`endif

endmodule

// File: rtl/key_event_sched.sv
// Key event scheduler: turns clean key levels into press / auto-repeat
// commands and serialises them onto one valid/ready channel through a
// round-robin arbiter feeding a single output register.
// Optional feature macro: KEY_SCHED_REPEAT_EN (DAS/ARR auto-repeat).
module key_event_sched
    import key_sched_pkg::*;
#(
    parameter int unsigned          KEY_NUM     = 3,
    parameter int unsigned          ID_W        = 2,
    parameter int unsigned          TIMER_W     = 24,
    parameter logic [TIMER_W-1:0]   DAS_CYCLES  = TIMER_W'(DEFAULT_DAS_CYCLES),
    parameter logic [TIMER_W-1:0]   ARR_CYCLES  = TIMER_W'(DEFAULT_ARR_CYCLES),
    parameter logic [KEY_NUM-1:0]   REPEAT_MASK = {KEY_NUM{1'b1}}
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [KEY_NUM-1:0] key_in,
    output logic               cmd_valid,
    input  logic               cmd_ready,
    output logic [ID_W-1:0]    cmd_id,
    output logic               cmd_repeat,
    output logic               cmd_drop
);

    logic [KEY_NUM-1:0] press_evt;
    logic [KEY_NUM-1:0] rep_evt;

    logic [KEY_NUM-1:0] pend_reg;
    logic [KEY_NUM-1:0] pend_rep_reg;
    logic [KEY_NUM-1:0] pend_next;
    logic [KEY_NUM-1:0] pend_rep_next;
    logic [KEY_NUM-1:0] merge_vec;

    logic               cmd_valid_reg;
    logic [ID_W-1:0]    cmd_id_reg;
    logic               cmd_rep_reg;
    logic               drop_reg;
    logic [ID_W-1:0]    rr_ptr_reg;

    logic               load;
    logic               grant_valid;
    logic [ID_W-1:0]    grant_idx;

    assign cmd_valid  = cmd_valid_reg;
    assign cmd_id     = cmd_id_reg;
    assign cmd_repeat = cmd_rep_reg;
    assign cmd_drop   = drop_reg;

    // The output register can take a new command when empty or being accepted
    assign load = ~cmd_valid_reg | cmd_ready;

    genvar gi;
    generate
        for (gi = 0; gi < KEY_NUM; gi++) begin : g_key
            logic gnt_this;
            logic evt;
            logic evt_rep;
            logic p_next;
            logic r_next;
            logic merge;

            key_repeat_timer
`ifdef KEY_SCHED_REPEAT_EN
            #(
                .TIMER_W    (TIMER_W),
                .DAS_CYCLES (DAS_CYCLES),
                .ARR_CYCLES (ARR_CYCLES),
                .REPEAT_EN  (REPEAT_MASK[gi])
            )
`endif
            u_timer (
                .clk       (clk),
                .reset     (reset),
                .key_in    (key_in[gi]),
                .press_evt (press_evt[gi]),
                .rep_evt   (rep_evt[gi])
            );

            assign gnt_this = load & grant_valid & (grant_idx == ID_W'(gi));
            assign evt      = press_evt[gi] | rep_evt[gi];
            assign evt_rep  = rep_evt[gi] & ~press_evt[gi];

            // Pending slot update: a grant frees the slot for a same-cycle event,
            // otherwise a new event coalesces (press wins over repeat) and a
            // released key drops a stale repeat.
            always_comb begin
                p_next = pend_reg[gi];
                r_next = pend_rep_reg[gi];
                merge  = 1'b0;
                if (gnt_this) begin
                    p_next = evt;
                    r_next = evt & evt_rep;
                end else if (evt) begin
                    if (pend_reg[gi]) begin
                        r_next = pend_rep_reg[gi] & evt_rep;
                        merge  = 1'b1;
                    end else begin
                        p_next = 1'b1;
                        r_next = evt_rep;
                    end
                end else if (!key_in[gi] && pend_reg[gi] && pend_rep_reg[gi]) begin
                    p_next = 1'b0;
                    r_next = 1'b0;
                end
            end

            assign pend_next[gi]     = p_next;
            assign pend_rep_next[gi] = r_next;
            assign merge_vec[gi]     = merge;
        end
    endgenerate

    // Round-robin search: scanning offsets from the far end lets the
    // nearest pending key at or after rr_ptr win
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = int'(KEY_NUM) - 1; k >= 0; k--) begin
            if (pend_reg[wrap_add(int'(rr_ptr_reg), k, int'(KEY_NUM))]) begin
                grant_valid = 1'b1;
                grant_idx   = ID_W'(wrap_add(int'(rr_ptr_reg), k, int'(KEY_NUM)));
            end
        end
    end

    // Pending bits and the merge pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_reg     <= '0;
            pend_rep_reg <= '0;
            drop_reg     <= 1'b0;
        end else begin
            pend_reg     <= pend_next;
            pend_rep_reg <= pend_rep_next;
            drop_reg     <= |merge_vec;
        end
    end

    // Output register and round-robin pointer; contents hold while stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_valid_reg <= 1'b0;
            cmd_id_reg    <= '0;
            cmd_rep_reg   <= 1'b0;
            rr_ptr_reg    <= '0;
        end else if (load) begin
            cmd_valid_reg <= grant_valid;
            if (grant_valid) begin
                cmd_id_reg  <= grant_idx;
                cmd_rep_reg <= pend_rep_reg[grant_idx];
                rr_ptr_reg  <= ID_W'(wrap_add(int'(grant_idx), 1, int'(KEY_NUM)));
            end
        end
    end

endmodule

// File: tb/tb_key_event_sched.sv
// Directed bench for key_event_sched with DAS=8, ARR=4, REPEAT_MASK=3'b011.
// Expected repeat traffic depends on whether KEY_SCHED_REPEAT_EN is defined.
module tb_key_event_sched;

`ifdef KEY_SCHED_REPEAT_EN
    localparam bit REP_ON = 1'b1;
`else
    localparam bit REP_ON = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic [2:0] key_in;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_id;
    logic       cmd_repeat;
    logic       cmd_drop;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    bit ev;
    int eid;
    bit erep;
    bit edrop;

    key_event_sched #(
        .KEY_NUM     (3),
        .ID_W        (2),
        .TIMER_W     (24),
        .DAS_CYCLES  (24'd8),
        .ARR_CYCLES  (24'd4),
        .REPEAT_MASK (3'b011)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .key_in     (key_in),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_id     (cmd_id),
        .cmd_repeat (cmd_repeat),
        .cmd_drop   (cmd_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One line per accepted command
    always @(negedge clk) begin
        if (!reset && cmd_valid && cmd_ready)
            $display("cyc=%0d cmd id=%0d rep=%0d", cyc, cmd_id, cmd_repeat);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d want=%0d", tag, act, exp);
        end
    endtask

    task automatic obs(input string tag, input int k, input bit v, input int id,
                       input bit rep, input bit drop);
        chk($sformatf("%s[%0d].valid", tag, k), 32'(cmd_valid), 32'(v));
        if (v) begin
            chk($sformatf("%s[%0d].id", tag, k), 32'(cmd_id), 32'(id));
            chk($sformatf("%s[%0d].rep", tag, k), 32'(cmd_repeat), 32'(rep));
        end
        chk($sformatf("%s[%0d].drop", tag, k), 32'(cmd_drop), 32'(drop));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        key_in    = 3'b000;
        cmd_ready = 1'b1;
        repeat (n) step();
    endtask

    initial begin
        reset     = 1'b1;
        key_in    = 3'b111;
        cmd_ready = 1'b1;

        // Reset held with all keys down: outputs at reset values
        repeat (3) step();
        chk("rst.valid", 32'(cmd_valid), 32'd0);
        chk("rst.id",    32'(cmd_id),    32'd0);
        chk("rst.rep",   32'(cmd_repeat), 32'd0);
        chk("rst.drop",  32'(cmd_drop),  32'd0);

        // Release with keys held: presses seen immediately, ids 0,1,2
        reset = 1'b0;
        for (int k = 0; k <= 7; k++) begin
            if (k == 5) key_in = 3'b000;
            ev = (k >= 2 && k <= 4);
            obs("rel", k, ev, k - 2, 1'b0, 1'b0);
            step();
        end
        idle(10);

        // Simultaneous press, held 27 cycles: keys 0/1 repeat, key 2 masked
        for (int k = 0; k <= 40; k++) begin
            key_in = (k < 27) ? 3'b111 : 3'b000;
            ev   = (k >= 2 && k <= 4) ||
                   (REP_ON && k >= 10 && k <= 27 && ((k - 10) % 4) < 2);
            eid  = (k <= 4) ? k - 2 : (k % 2);
            erep = (k >= 10);
            obs("sim", k, ev, eid, erep, 1'b0);
            step();
        end
        idle(10);

        // Single 3-cycle tap on key 0
        for (int k = 0; k <= 14; k++) begin
            key_in = (k < 3) ? 3'b001 : 3'b000;
            obs("tap", k, (k == 2), 0, 1'b0, 1'b0);
            step();
        end
        idle(10);

        // Key 1 held N..N+30: press at +2, repeats at +10,+14,...,+30
        for (int k = 0; k <= 40; k++) begin
            key_in = (k <= 30) ? 3'b010 : 3'b000;
            ev   = (k == 2) || (REP_ON && k >= 10 && k <= 30 && ((k - 10) % 4) == 0);
            erep = (k >= 10);
            obs("hold", k, ev, 1, erep, 1'b0);
            step();
        end
        idle(10);

        // Key 1 released during DAS (count 3): no repeat
        for (int k = 0; k <= 20; k++) begin
            key_in = (k < 5) ? 3'b010 : 3'b000;
            obs("dasrel", k, (k == 2), 1, 1'b0, 1'b0);
            step();
        end
        idle(10);

        // Backpressure: stall 12 cycles, second tap pends, third tap merges
        for (int k = 0; k <= 20; k++) begin
            key_in    = (k < 2 || k == 4 || k == 7) ? 3'b001 : 3'b000;
            cmd_ready = (k >= 14);
            ev    = (k >= 2 && k <= 15);
            edrop = (k == 8);
            obs("bp", k, ev, 0, 1'b0, edrop);
            step();
        end
        idle(10);

        // Reset while key 0 is in ARR with a command stuck and one pending
        cmd_ready = 1'b0;
        key_in    = 3'b001;
        for (int k = 0; k <= 12; k++) begin
            if (k == 2) chk("arr.stall.valid", 32'(cmd_valid), 32'd1);
            step();
        end
        reset = 1'b1;
        step();
        chk("arr.rst.valid", 32'(cmd_valid), 32'd0);
        chk("arr.rst.id",    32'(cmd_id),    32'd0);
        chk("arr.rst.rep",   32'(cmd_repeat), 32'd0);
        chk("arr.rst.drop",  32'(cmd_drop),  32'd0);
        key_in    = 3'b000;
        cmd_ready = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 0; k <= 15; k++) begin
            chk($sformatf("arr.post[%0d].valid", k), 32'(cmd_valid), 32'd0);
            step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/key_event_sched.md
# key_event_sched

Converts the clean, debounced button levels from the input filter into discrete game commands for the Tetris game controller. Per key it detects presses and, when enabled, generates delayed-auto-shift (DAS) and auto-repeat (ARR) events. Pending events from all keys share one command channel through a round-robin arbiter with a valid/ready handshake. It sits between the input filter and the game logic FSM.

## Interface
- KEY_NUM, 3, number of keys; bit i of `key_in` is key id i
- ID_W, 2, width of `cmd_id`; must satisfy 2^ID_W >= KEY_NUM
- TIMER_W, 24, width of each per-key countdown
- DAS_CYCLES, 24'd6_000_000, number of held cycles from a press event to the first repeat event
- ARR_CYCLES, 24'd1_500_000, number of cycles between successive repeat events
- REPEAT_MASK, {KEY_NUM{1'b1}}, bit i = 1 allows key i to auto-repeat
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- key_in  in  KEY_NUM  clean key levels from the filter; 1 = pressed
- cmd_valid  out  1  a command is presented
- cmd_ready  in  1  consumer accepts the command this cycle
- cmd_id  out  ID_W  key id of the presented command
- cmd_repeat  out  1  0 = press event, 1 = auto-repeat event
- cmd_drop  out  1  one-cycle pulse when an event merges into an already-pending one

## Operation
- Every key has a registered `key_prev`. A press is detected when `key_in[i] & ~key_prev[i]`.
- Each key runs an FSM with states IDLE, DAS, ARR, HOLD:
  - IDLE to DAS on a press. The press sets pending[i] with rep[i]=0. The timer loads DAS_CYCLES-1.
  - In DAS, the timer decrements. When it reaches 0:
    - if REPEAT_MASK[i]=1: go to ARR, set pending with rep=1, load ARR_CYCLES-1;
    - otherwise go to HOLD.
  - In ARR, the timer decrements. At 0 it sets pending with rep=1 and reloads ARR_CYCLES-1.
  - From any state, `key_in[i]=0` returns the FSM to IDLE and clears the timer. A pending press (rep=0) is kept. A pending repeat (rep=1) is discarded.
- Coalescing: an event that arrives while pending[i] is already set leaves one pending entry and pulses `cmd_drop`. In that entry, rep is the AND of the old and new rep values, so a press is never downgraded to a repeat.
- Arbiter and output register:
  - When the output register is empty, or is accepted this cycle (`cmd_valid & cmd_ready`), the arbiter grants the first pending key at or after `rr_ptr`, wrapping modulo KEY_NUM.
  - The granted id and rep are loaded into the output register and that pending bit is cleared. `rr_ptr` becomes grant+1, wrapping modulo KEY_NUM.
- If a key is granted in the same cycle that a new event arrives for it, the new event stays pending and `cmd_drop` does not pulse.
- While `cmd_valid=1` and `cmd_ready=0`, `cmd_id` and `cmd_repeat` hold stable.

## Timing
- Reset values: `cmd_valid`=0, `cmd_id`=0, `cmd_repeat`=0, `cmd_drop`=0. All FSMs IDLE, timers 0, pending 0, `key_prev` 0, `rr_ptr` 0.
- If `key_in[i]` is high when reset releases, the first cycle after release registers a press.
- Press latency: `key_in` rises in cycle N, pending is set in N+1, and `cmd_valid` is high in N+2 if the channel is free.
- First repeat: pending is set DAS_CYCLES cycles after the press pending. Later repeats follow every ARR_CYCLES cycles.
- Throughput: one command per cycle while `cmd_ready=1`.
- Reset mid-operation returns every register to its reset value in the next cycle. In-flight and pending commands are lost.

## Configuration
- KEY_SCHED_REPEAT_EN
  - Defined: DAS/ARR FSMs and timers are compiled in, as described above.
  - Undefined: only the edge detector and pending press logic exist. No timers, `cmd_repeat` is tied to 0, and REPEAT_MASK, DAS_CYCLES, ARR_CYCLES and TIMER_W are ignored.

## Structure
- Package `key_sched_pkg`:
  - FSM state typedef (IDLE, DAS, ARR, HOLD);
  - key id constants KEY_LEFT=0, KEY_RIGHT=1, KEY_ROTATE=2;
  - default DAS/ARR cycle constants.
- Sub-module `key_repeat_timer`: one instance per key via generate. It holds the FSM, timer and `key_prev`, and outputs one-cycle `press_evt` and `rep_evt` strobes.
- The top level holds the pending bits, the round-robin arbiter and the output register.

## Test plan
Bench configuration for all scenarios: KEY_NUM=3, DAS_CYCLES=8, ARR_CYCLES=4, REPEAT_MASK=3'b011, `cmd_ready`=1 unless stated.
- Reset: hold `reset` with key_in=3'b111 → all outputs 0. One cycle after release key_in is seen as pressed; commands follow for ids 0, 1, 2.
- Single tap: key0 high for 3 cycles from cycle N → exactly one command, id0 rep0, with `cmd_valid` in cycle N+2 only.
- Hold key1 from N to N+30 → commands at N+2 (rep0), then N+10, N+14, N+18, N+22, N+26, N+30 (rep1). None after release.
- Simultaneous rise of key_in=3'b111 → ids 0, 1, 2 on three consecutive cycles. Key2 stays held but never repeats (mask=0).
- Backpressure:
  - key0 pressed, `cmd_ready`=0 for 12 cycles → `cmd_valid` held with id0 stable;
  - a second tap during the stall is kept pending; a third tap pulses `cmd_drop` once;
  - after ready rises → two commands, both id0 rep0.
- Release and reset during repeat:
  - key1 released at DAS count 3 → no repeat command;
  - `reset` asserted while key0 is in ARR with a command pending → `cmd_valid`=0 in the next cycle and no stale command after release.
